// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: moves at most STEP bit positions per BUSY cycle.
// Optional build macro ITER_SHIFTER_FLUSH_EN adds the i_flush abort input.
module iter_shifter #(
   parameter int WIDTH = 32,
   parameter int BITS  = $clog2(WIDTH),
   parameter int STEP  = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
`ifdef ITER_SHIFTER_FLUSH_EN
   input  logic             i_flush,
`endif
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_operand,
   input  logic [BITS-1:0]  i_amount,
   input  logic             i_dir,
   input  logic             i_mode,
   input  logic             i_arith,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic [1:0]       o_state
);

   // Handshake: a request transfers on a rising edge with i_valid && o_ready;
   // a result transfers on a rising edge with o_valid && i_ready. The requester
   // holds its request until o_ready; o_result stays frozen while o_valid is
   // high and i_ready is low.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [BITS:0] STEP_W  = (BITS+1)'(STEP);
   localparam logic [BITS:0] WIDTH_W = (BITS+1)'(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [BITS-1:0]  rem;
   logic             dir_q;
   logic             mode_q;
   logic             fill_q;

   logic [BITS:0]    rem_ext;
   logic [BITS:0]    s;
   logic [BITS-1:0]  rem_nx;
   logic [WIDTH-1:0] shifted;

   assign o_state = state;

   always_comb begin
      rem_ext = {1'b0, rem};
      s       = (rem_ext >= STEP_W) ? STEP_W : rem_ext;
      // s never exceeds rem, which is below WIDTH, so the low bits are exact
      rem_nx  = rem - s[BITS-1:0];
      shifted = work;
      if (mode_q) begin
         if (dir_q)
            shifted = work << s;
         else if (fill_q)
            shifted = ~(~work >> s);
         else
            shifted = work >> s;
      end else begin
         if (dir_q)
            shifted = (work << s) | (work >> (WIDTH_W - s));
         else
            shifted = (work >> s) | (work << (WIDTH_W - s));
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         o_valid  <= 1'b0;
         o_ready  <= 1'b1;
         o_result <= '0;
         rem      <= '0;
         work     <= '0;
         dir_q    <= 1'b0;
         mode_q   <= 1'b0;
         fill_q   <= 1'b0;
      end else
`ifdef ITER_SHIFTER_FLUSH_EN
      if (i_flush) begin
         state   <= IDLE;
         o_valid <= 1'b0;
         o_ready <= 1'b1;
         rem     <= '0;
      end else
`endif
      begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  work    <= i_operand;
                  dir_q   <= i_dir;
                  mode_q  <= i_mode;
                  // mode gates first so an undriven arith cannot leak into rotates
                  fill_q  <= i_mode & ~i_dir & i_arith & i_operand[WIDTH-1];
                  o_ready <= 1'b0;
                  if (i_amount == '0) begin
                     state    <= DONE;
                     o_valid  <= 1'b1;
                     o_result <= i_operand;
                     rem      <= '0;
                  end else begin
                     state <= BUSY;
                     rem   <= i_amount;
                  end
               end
            end
            BUSY: begin
               work <= shifted;
               rem  <= rem_nx;
               if (rem_nx == '0) begin
                  state    <= DONE;
                  o_valid  <= 1'b1;
                  o_result <= shifted;
               end
            end
            DONE: begin
               if (i_ready) begin
                  state   <= IDLE;
                  o_valid <= 1'b0;
                  o_ready <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               o_valid <= 1'b0;
               o_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: directed vector table, hand-written handshake/reset
// sequences and randomized requests against a behavioural shift model.
module tb_iter_shifter;

   localparam int WIDTH = 32;
   localparam int BITS  = 5;
   localparam int STEP  = 4;

   logic             i_clk;
   logic             i_rst_n;
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_operand;
   logic [BITS-1:0]  i_amount;
   logic             i_dir;
   logic             i_mode;
   logic             i_arith;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_result;
   logic [1:0]       o_state;
`ifdef ITER_SHIFTER_FLUSH_EN
   logic             i_flush;
`endif

   iter_shifter #(.WIDTH(WIDTH), .BITS(BITS), .STEP(STEP)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
`ifdef ITER_SHIFTER_FLUSH_EN
      .i_flush   (i_flush),
`endif
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_operand (i_operand),
      .i_amount  (i_amount),
      .i_dir     (i_dir),
      .i_mode    (i_mode),
      .i_arith   (i_arith),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_result  (o_result),
      .o_state   (o_state)
   );

   // clock / reset
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] exp_q[$];

   typedef struct {
      string            name;
      logic [WIDTH-1:0] operand;
      logic [BITS-1:0]  amount;
      logic             dir;
      logic             mode;
      logic             arith;
      logic [WIDTH-1:0] result;
      int               lat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference: operations 0..4 = SLL, SRL, SRA, ROL, ROR
   function automatic logic [WIDTH-1:0] model(input int op, input logic [WIDTH-1:0] v, input int a);
      logic signed [WIDTH-1:0] sv;
      sv = v;
      case (op)
         0: return v << a;
         1: return v >> a;
         2: return sv >>> a;
         3: return (a == 0) ? v : ((v << a) | (v >> (WIDTH - a)));
         default: return (a == 0) ? v : ((v >> a) | (v << (WIDTH - a)));
      endcase
   endfunction

   function automatic int model_lat(input int a);
      return (a == 0) ? 1 : ((a + STEP - 1) / STEP) + 1;
   endfunction

   // driver: present a request from IDLE and take the acceptance edge
   task automatic issue(input string nm, input logic [WIDTH-1:0] op, input logic [BITS-1:0] a,
                        input logic d, input logic m, input logic ar, input logic [WIDTH-1:0] exp);
      chk({nm, " ready before issue"}, 32'(o_ready), 32'd1);
      i_operand = op;
      i_amount  = a;
      i_dir     = d;
      i_mode    = m;
      i_arith   = ar;
      i_valid   = 1'b1;
      exp_q.push_back(exp);
      @(posedge i_clk);
      #1;
      i_valid   = 1'b0;
      i_operand = $urandom;
      i_amount  = BITS'($urandom);
      chk({nm, " ready dropped"}, 32'(o_ready), 32'd0);
   endtask

   // wait for the result, hold it for `stall` cycles, then hand it off
   task automatic collect(input string nm, input int exp_lat, input int stall);
      int lat;
      logic [WIDTH-1:0] exp;
      exp = exp_q.pop_front();
      lat = 1;
      while (!o_valid && lat < 40) begin
         @(posedge i_clk);
         #1;
         lat++;
      end
      chk({nm, " valid"}, 32'(o_valid), 32'd1);
      chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
      chk({nm, " result"}, o_result, exp);
      for (int k = 0; k < stall; k++) begin
         @(posedge i_clk);
         #1;
         chk({nm, " held result"}, o_result, exp);
         chk({nm, " held valid"}, 32'(o_valid), 32'd1);
      end
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      i_ready = 1'b0;
      chk({nm, " valid cleared"}, 32'(o_valid), 32'd0);
      chk({nm, " ready back"}, 32'(o_ready), 32'd1);
   endtask

   initial begin
      int op;
      int a;
      logic [WIDTH-1:0] v;
      logic d;
      logic m;
      logic ar;

      i_rst_n   = 1'b0;
      i_valid   = 1'b0;
      i_ready   = 1'b0;
      i_operand = '0;
      i_amount  = '0;
      i_dir     = 1'b0;
      i_mode    = 1'b0;
      i_arith   = 1'b0;
`ifdef ITER_SHIFTER_FLUSH_EN
      i_flush   = 1'b0;
`endif
      repeat (3) @(posedge i_clk);
      #1;
      chk("reset ready", 32'(o_ready), 32'd1);
      chk("reset valid", 32'(o_valid), 32'd0);
      chk("reset result", o_result, 32'h0);
      chk("reset state", 32'(o_state), 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      vecs.push_back('{"sll3",    32'h0000AF05, 5'd3,  1'b1, 1'b1, 1'b0, 32'h00057828, 2});
      vecs.push_back('{"sra31",   32'h80000000, 5'd31, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 9});
      vecs.push_back('{"srl31",   32'h80000000, 5'd31, 1'b0, 1'b1, 1'b0, 32'h00000001, 9});
      vecs.push_back('{"rol4",    32'h80000001, 5'd4,  1'b1, 1'b0, 1'b0, 32'h00000018, 2});
      vecs.push_back('{"ror1",    32'h00000001, 5'd1,  1'b0, 1'b0, 1'bx, 32'h80000000, 2});
      vecs.push_back('{"sll0",    32'h12345678, 5'd0,  1'b1, 1'b1, 1'b0, 32'h12345678, 1});
      vecs.push_back('{"sra0",    32'h87654321, 5'd0,  1'b0, 1'b1, 1'b1, 32'h87654321, 1});
      vecs.push_back('{"ror0",    32'hDEADBEEF, 5'd0,  1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1});
      vecs.push_back('{"sll4",    32'h0000000F, 5'd4,  1'b1, 1'b1, 1'b1, 32'h000000F0, 2});
      vecs.push_back('{"sll5",    32'h0000000F, 5'd5,  1'b1, 1'b1, 1'b0, 32'h000001E0, 3});
      vecs.push_back('{"sra4",    32'hF0000000, 5'd4,  1'b0, 1'b1, 1'b1, 32'hFF000000, 2});
      vecs.push_back('{"sra_pos", 32'h70000000, 5'd8,  1'b0, 1'b1, 1'b1, 32'h00700000, 3});
      vecs.push_back('{"ror8",    32'h12345678, 5'd8,  1'b0, 1'b0, 1'b1, 32'h78123456, 3});
      vecs.push_back('{"rol31",   32'h12345678, 5'd31, 1'b1, 1'b0, 1'b0, 32'h091A2B3C, 9});

      foreach (vecs[i]) begin
         issue(vecs[i].name, vecs[i].operand, vecs[i].amount, vecs[i].dir, vecs[i].mode,
               vecs[i].arith, vecs[i].result);
         collect(vecs[i].name, vecs[i].lat, 0);
      end

      // backpressure: hold DONE five cycles and pulse a request that must be ignored
      issue("bp", 32'h0000AF05, 5'd3, 1'b1, 1'b1, 1'b0, 32'h00057828);
      @(posedge i_clk);
      #1;
      chk("bp valid", 32'(o_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin
            i_operand = 32'hFFFF0000;
            i_amount  = 5'd0;
            i_valid   = 1'b1;
         end
         @(posedge i_clk);
         #1;
         i_valid = 1'b0;
         chk("bp held valid", 32'(o_valid), 32'd1);
         chk("bp held ready", 32'(o_ready), 32'd0);
         chk("bp held result", o_result, 32'h00057828);
      end
      void'(exp_q.pop_front());
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      i_ready = 1'b0;
      chk("bp released valid", 32'(o_valid), 32'd0);
      issue("bp next", 32'h00000003, 5'd2, 1'b1, 1'b1, 1'b0, 32'h0000000C);
      collect("bp next", 2, 0);

      // asynchronous reset in the middle of a long shift
      issue("rst", 32'h00000001, 5'd20, 1'b1, 1'b1, 1'b0, 32'h00100000);
      @(posedge i_clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("rst valid", 32'(o_valid), 32'd0);
      chk("rst ready", 32'(o_ready), 32'd1);
      chk("rst result", o_result, 32'h0);
      chk("rst state", 32'(o_state), 32'd0);
      exp_q.delete();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      issue("after rst", 32'h00000001, 5'd20, 1'b1, 1'b1, 1'b0, 32'h00100000);
      collect("after rst", 6, 1);

`ifdef ITER_SHIFTER_FLUSH_EN
      issue("flush", 32'h00000001, 5'd20, 1'b1, 1'b1, 1'b0, 32'h00100000);
      @(posedge i_clk);
      #1;
      i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      chk("flush ready", 32'(o_ready), 32'd1);
      chk("flush state", 32'(o_state), 32'd0);
      for (int k = 0; k < 8; k++) begin
         @(posedge i_clk);
         #1;
         chk("flush no valid", 32'(o_valid), 32'd0);
      end
      exp_q.delete();
`endif

      // randomized requests against the model
      for (int n = 0; n < 1024; n++) begin
         op = $urandom_range(0, 4);
         a  = $urandom_range(0, WIDTH - 1);
         v  = $urandom;
         d  = (op == 0 || op == 3);
         m  = (op <= 2);
         ar = (op == 2) ? 1'b1 : (op == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         issue($sformatf("rnd%0d op%0d a%0d", n, op, a), v, BITS'(a), d, m, ar, model(op, v, a));
         collect($sformatf("rnd%0d op%0d a%0d", n, op, a), model_lat(a), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // global watchdog so a stuck DUT still ends in a summary
   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Multi-cycle shift/rotate unit. Small-area alternative to the single-cycle combinational shifter.
- Shifts by at most STEP positions per clock, with a valid/ready handshake on both sides.
- Uses the same dir/mode/arith encodings as the combinational shifter, so the ALU/execute stage can issue to either one.

Parameters:
- WIDTH, 32, operand/result width in bits.
- BITS, $clog2(WIDTH), width of the shift amount.
- STEP, 4, maximum positions shifted per BUSY cycle; power of two, 1..WIDTH.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request.
- i_operand  in  WIDTH  value to shift.
- i_amount  in  BITS  shift amount, 0..WIDTH-1.
- i_dir  in  1  1=left, 0=right.
- i_mode  in  1  1=shift, 0=rotate.
- i_arith  in  1  1=arithmetic (right shift only), 0=logical; ignored for rotate and left shift.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_result  out  WIDTH  shifted/rotated value.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, o_valid=0, o_ready=1, o_result=0, internal remaining count=0.
- FSM states: IDLE, BUSY, DONE.
- o_ready=1 only in IDLE. o_valid=1 only in DONE.
- IDLE:
  - On i_valid, capture operand, amount, dir, mode and arith into registers.
  - Capture the fill bit = arith & ~dir & mode ? operand[WIDTH-1] : 0.
  - amount==0: go to DONE; result=operand.
  - Otherwise: go to BUSY with rem=amount.
- BUSY, each cycle:
  - s = (rem >= STEP) ? STEP : rem.
  - Shift/rotate the working register by s in the captured direction.
  - rem -= s.
  - When rem==0 after the update, go to DONE.
- Shift fill:
  - Left shift: zero fill.
  - Right logical: zero fill.
  - Right arithmetic: filled with the captured sign bit on every step, not the current MSB (they are identical; the sign bit is registered explicitly).
  - Rotate: bits wrap; no fill.
- DONE:
  - o_result = working register, held stable.
  - i_ready=1: go to IDLE.
  - No back-to-back issue: acceptance is possible again from the following cycle.
- Latency, counted from the acceptance edge to o_valid=1:
  - 1 cycle for amount==0.
  - ceil(amount/STEP)+1 cycles otherwise.
  - Maximum is ceil((WIDTH-1)/STEP)+1 (9 for defaults).
- Inputs other than i_valid and i_ready are don't-care outside the acceptance cycle.
- i_valid while not in IDLE is ignored; the requester must hold the request until o_ready.
- o_result must be stable whenever o_valid=1 && i_ready=0.
- Arithmetic/width rules:
  - All internal shifts are WIDTH bits; there is no widening.
  - Results must equal the combinational definitions:
    - SLL: in<<a.
    - SRL: in>>a.
    - SRA: $signed(in)>>>a.
    - ROL: (in<<a)|(in>>(WIDTH-a)).
    - ROR: (in>>a)|(in<<(WIDTH-a)).
    - With a==0 every case gives in.
- Reset mid-operation: any state returns to IDLE immediately, the result is dropped, and o_result is cleared to 0.
- No X propagation: arith=X with mode=rotate must not corrupt the result.

Optional Feature:
- ITER_SHIFTER_FLUSH_EN defined:
  - Adds input i_flush (1 bit).
  - When i_flush=1 in any state, the next state is IDLE, o_valid=0 next cycle, and the result is discarded; o_result keeps its last value.
  - i_flush has priority over i_valid and i_ready in the same cycle. No request is accepted in a cycle where i_flush=1.
- Undefined: the port is absent and the FSM has no flush path.

Test Plan:
- SLL: in=0x0000AF05, a=3, dir=1, mode=1 -> o_result=0x00057828, o_valid 2 cycles after acceptance.
- SRA: in=0x80000000, a=31, dir=0, mode=1, arith=1 -> 0xFFFFFFFF after 9 cycles. Same with arith=0 -> 0x00000001.
- Rotates: ROL in=0x80000001, a=4 -> 0x00000018. ROR in=0x00000001, a=1 -> 0x80000000 with arith=X. a=0 in any mode -> result=in, o_valid 1 cycle after acceptance.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_result and o_valid stable, o_ready=0, and a pulsed i_valid is ignored. i_ready=1 -> IDLE; the next request is accepted one cycle later.
- Reset: assert i_rst_n=0 mid-BUSY (SLL a=20) -> o_valid=0, o_ready=1, o_result=0 asynchronously. With ITER_SHIFTER_FLUSH_EN, i_flush mid-BUSY -> IDLE next cycle, no o_valid pulse.
- Random: 1024 requests over all 5 operations with random operand and amount and random i_ready stalls -> every result matches the model, and latency equals ceil(a/STEP)+1.
